// File: rtl/crop_norm_sequencer_if.sv
// Frame-control and lane handshake bundle for crop_norm_sequencer.
// The sequencer uses the slave modport; the host/lane side uses the master modport.
interface crop_norm_sequencer_if #(
  parameter int unsigned NUM_LANES = 4
);
  logic                 frame_start;
  logic [7:0]           frame_norm_denominator;
  logic                 seq_ap_idle;
  logic [NUM_LANES-1:0] lane_ap_ready;
  logic [NUM_LANES-1:0] lane_ap_done;
  logic [NUM_LANES-1:0] lane_ap_start;
  logic [7:0]           norm_denominator;
  logic                 norm_denominator_tvalid;
  logic                 busy;
  logic                 frame_done;
  logic [15:0]          frame_count;
  logic                 timeout_err;

  modport master (
    output frame_start, frame_norm_denominator, seq_ap_idle, lane_ap_ready, lane_ap_done,
    input  lane_ap_start, norm_denominator, norm_denominator_tvalid, busy, frame_done,
           frame_count, timeout_err
  );

  modport slave (
    input  frame_start, frame_norm_denominator, seq_ap_idle, lane_ap_ready, lane_ap_done,
    output lane_ap_start, norm_denominator, norm_denominator_tvalid, busy, frame_done,
           frame_count, timeout_err
  );
endinterface

// File: rtl/crop_norm_sequencer.sv
// Frame controller: loads the denominator into all lane LUTs, starts every lane together,
// collects their done pulses and reports completion. Define CNS_TIMEOUT_EN for the RUN watchdog.
module crop_norm_sequencer #(
  parameter int unsigned NUM_LANES      = 4,
  parameter int unsigned LUT_LATENCY    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  crop_norm_sequencer_if.slave bus
);
  localparam int unsigned LOAD_W = (LUT_LATENCY > 1) ? $clog2(LUT_LATENCY) : 1;
  localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LUT_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [LOAD_W-1:0]    r_load_cnt;
  logic [NUM_LANES-1:0] r_mask;
  logic [7:0]           r_den;
  logic                 r_tvalid;
  logic                 r_start;
  logic                 r_busy;
  logic                 r_frame_done;
  logic [15:0]          r_frame_count;

  logic [NUM_LANES-1:0] w_mask_next;
  logic                 w_all_done;

`ifdef CNS_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_run_cnt;
  logic            r_timeout_err;
`endif

  // Dones in the start cycle belong to the previous frame and are masked off.
  assign w_mask_next = r_mask | (r_start ? '0 : bus.lane_ap_done);
  assign w_all_done  = &w_mask_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_load_cnt    <= '0;
      r_mask        <= '0;
      r_den         <= 8'd0;
      r_tvalid      <= 1'b0;
      r_start       <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 16'd0;
`ifdef CNS_TIMEOUT_EN
      r_run_cnt     <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      // NOTE: strobes default low here so each one is a single-cycle pulse unless a state re-arms it.
      r_tvalid     <= 1'b0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.frame_start) begin
            r_den      <= (bus.frame_norm_denominator == 8'd0) ? 8'd1
                                                                : bus.frame_norm_denominator;
            r_tvalid   <= 1'b1;
            r_load_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_LOAD;
`ifdef CNS_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (r_load_cnt == LOAD_LAST) begin
            r_state <= S_ARM;
          end else begin
            r_load_cnt <= r_load_cnt + LOAD_W'(1);
          end
        end
        S_ARM: begin
          if (bus.seq_ap_idle && (&bus.lane_ap_ready)) begin
            r_start <= 1'b1;
            r_mask  <= '0;
            r_state <= S_RUN;
`ifdef CNS_TIMEOUT_EN
            r_run_cnt <= '0;
`endif
          end
        end
        S_RUN: begin
          r_mask <= w_mask_next;
          if (w_all_done) begin
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            r_state       <= S_DONE;
          end
`ifdef CNS_TIMEOUT_EN
          else if (r_run_cnt == TO_LAST) begin
            r_timeout_err <= 1'b1;
            r_frame_done  <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_run_cnt <= r_run_cnt + TO_W'(1);
          end
`endif
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.lane_ap_start           = {NUM_LANES{r_start}};
  assign bus.norm_denominator        = r_den;
  assign bus.norm_denominator_tvalid = r_tvalid;
  assign bus.busy                    = r_busy;
  assign bus.frame_done              = r_frame_done;
  assign bus.frame_count             = r_frame_count;
`ifdef CNS_TIMEOUT_EN
  assign bus.timeout_err             = r_timeout_err;
`else
  assign bus.timeout_err             = 1'b0;
`endif

endmodule

// File: tb/tb_crop_norm_sequencer.sv
// Directed, table-driven bench for crop_norm_sequencer (4 lanes, LUT latency 2).
// Watchdog scenario runs only when CNS_TIMEOUT_EN is defined.
module tb_crop_norm_sequencer;
  localparam int unsigned NL      = 4;
  localparam int unsigned LUT_LAT = 2;
  localparam int unsigned TO_CYC  = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  crop_norm_sequencer_if #(.NUM_LANES(NL)) bus ();

  crop_norm_sequencer #(
    .NUM_LANES     (NL),
    .LUT_LATENCY   (LUT_LAT),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] den;
    logic [7:0] exp_den;
    int         gap;
  } vec_t;

  int checks    = 0;
  int errors    = 0;
  int exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.frame_start            = 1'b0;
    bus.frame_norm_denominator = 8'd0;
    bus.seq_ap_idle            = 1'b1;
    bus.lane_ap_ready          = 4'hF;
    bus.lane_ap_done           = 4'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " lane_ap_start"}, bus.lane_ap_start, 0);
    check({tag, " norm_den"}, bus.norm_denominator, 0);
    check({tag, " tvalid"}, bus.norm_denominator_tvalid, 0);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " frame_done"}, bus.frame_done, 0);
    check({tag, " frame_count"}, bus.frame_count, 0);
    check({tag, " timeout_err"}, bus.timeout_err, 0);
  endtask

  // Full frame with all lanes ready; lane i reports done (i+1)*gap cycles after the start pulse.
  task automatic run_frame(input string tag, input logic [7:0] den, input logic [7:0] exp_den,
                           input int gap);
    int n;
    int extra_tv;
    int bad;
    bus.frame_start            = 1'b1;
    bus.frame_norm_denominator = den;
    tick();
    bus.frame_start = 1'b0;
    check({tag, " tvalid"}, bus.norm_denominator_tvalid, 1);
    check({tag, " norm_den"}, bus.norm_denominator, exp_den);
    check({tag, " busy"}, bus.busy, 1);
    check({tag, " timeout_err clr"}, bus.timeout_err, 0);
    n        = 1;
    extra_tv = 0;
    while (bus.lane_ap_start == 4'h0 && n < 20) begin
      tick();
      n++;
      extra_tv += int'(bus.norm_denominator_tvalid);
    end
    check({tag, " start latency"}, n, LUT_LAT + 2);
    check({tag, " start value"}, bus.lane_ap_start, 4'hF);
    bad = 0;
    for (int k = 1; k <= 4 * gap; k++) begin
      tick();
      bad      += int'(bus.frame_done) + int'(bus.lane_ap_start != 4'h0);
      extra_tv += int'(bus.norm_denominator_tvalid);
      bus.lane_ap_done = (k % gap == 0) ? (4'b0001 << (k / gap - 1)) : 4'b0000;
    end
    tick();
    bus.lane_ap_done = 4'h0;
    exp_count++;
    check({tag, " frame_done"}, bus.frame_done, 1);
    check({tag, " frame_count"}, bus.frame_count, exp_count);
    check({tag, " den held"}, bus.norm_denominator, exp_den);
    tick();
    check({tag, " frame_done pulse"}, bus.frame_done, 0);
    check({tag, " busy idle"}, bus.busy, 0);
    check({tag, " early/extra pulses"}, bad, 0);
    check({tag, " extra tvalid"}, extra_tv, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   bad;
    int   n;

    vecs[0] = '{den: 8'd200, exp_den: 8'd200, gap: 10};
    vecs[1] = '{den: 8'd0,   exp_den: 8'd1,   gap: 3};
    vecs[2] = '{den: 8'd255, exp_den: 8'd255, gap: 1};
    vecs[3] = '{den: 8'd1,   exp_den: 8'd1,   gap: 2};

    drive_idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].den, vecs[i].exp_den, vecs[i].gap);
    end

    // ARM stall: one lane not ready for about 50 cycles.
    bus.lane_ap_ready          = 4'b1011;
    bus.frame_start            = 1'b1;
    bus.frame_norm_denominator = 8'd50;
    tick();
    bus.frame_start = 1'b0;
    bad = 0;
    for (int k = 0; k < 52; k++) begin
      tick();
      bad += int'(bus.lane_ap_start != 4'h0) + int'(bus.busy != 1'b1);
    end
    check("stall no start/busy", bad, 0);
    bus.lane_ap_ready = 4'hF;
    tick();
    check("stall release start", bus.lane_ap_start, 4'hF);
    tick();
    bus.lane_ap_done = 4'hF;
    tick();
    bus.lane_ap_done = 4'h0;
    exp_count++;
    check("stall frame_done", bus.frame_done, 1);
    check("stall frame_count", bus.frame_count, exp_count);
    tick();

    // frame_start held through RUN; start-cycle done ignored; repeated lane0 dones.
    bus.frame_start            = 1'b1;
    bus.frame_norm_denominator = 8'd77;
    tick();
    repeat (3) tick();
    check("hold start pulse", bus.lane_ap_start, 4'hF);
    bus.lane_ap_done = 4'hF;
    bad = 0;
    tick();
    bad += int'(bus.frame_done);
    bus.lane_ap_done = 4'b0001;
    tick();
    bad += int'(bus.frame_done);
    bus.lane_ap_done = 4'b0000;
    tick();
    bad += int'(bus.frame_done);
    bus.lane_ap_done = 4'b0001;
    tick();
    bad += int'(bus.frame_done);
    bus.lane_ap_done = 4'b0000;
    tick();
    bad += int'(bus.frame_done);
    check("hold no early done", bad, 0);
    bus.lane_ap_done = 4'b1110;
    bus.frame_start  = 1'b0;
    tick();
    bus.lane_ap_done = 4'h0;
    exp_count++;
    check("hold frame_done", bus.frame_done, 1);
    check("hold frame_count", bus.frame_count, exp_count);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      bad += int'(bus.frame_done) + int'(bus.norm_denominator_tvalid);
    end
    check("hold single frame", bad, 0);
    check("hold busy idle", bus.busy, 0);
    check("hold count stable", bus.frame_count, exp_count);

`ifdef CNS_TIMEOUT_EN
    // Lane 2 never reports done: watchdog ends the frame.
    bus.frame_start            = 1'b1;
    bus.frame_norm_denominator = 8'd9;
    tick();
    bus.frame_start = 1'b0;
    repeat (3) tick();
    check("to start", bus.lane_ap_start, 4'hF);
    tick();
    bus.lane_ap_done = 4'b1011;
    tick();
    bus.lane_ap_done = 4'b0000;
    n = 2;
    while (!bus.frame_done && n < 200) begin
      tick();
      n++;
    end
    check("to run cycles", n, TO_CYC);
    check("to timeout_err", bus.timeout_err, 1);
    check("to frame_count", bus.frame_count, exp_count);
    tick();
    check("to sticky", bus.timeout_err, 1);
    run_frame("after_to", 8'd33, 8'd33, 2);
`else
    n = 0;
`endif

    // Reset mid-RUN aborts the frame and clears the counter.
    bus.frame_start            = 1'b1;
    bus.frame_norm_denominator = 8'd120;
    tick();
    bus.frame_start = 1'b0;
    repeat (3) tick();
    tick();
    bus.lane_ap_done = 4'b0011;
    tick();
    bus.lane_ap_done = 4'b0000;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midrun reset");
    @(posedge clk);
    #1;
    reset     = 1'b0;
    exp_count = 0;
    tick();
    check("post reset idle", bus.busy, 0);
    run_frame("post_reset", 8'd90, 8'd90, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
